spi_shift: RTL and testbench

- Serial data engine directly downstream of spi_clgen: consumes its rising/falling-edge strobes and produces MOSI, samples MISO, and assembles the received character.
- Drives tip and lstclk back to spi_clgen to gate and terminate SCLK generation.
- Character length 1..CHAR_LEN_MAX bits.
- MSB- or LSB-first order; transmit and receive edges are selectable independently.

---
 rtl/spi_shift_if.sv | 26 ++
 rtl/spi_shift.sv | 107 ++++++++++
 tb/tb_spi_shift.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_shift_if.sv
// Host-side bus of spi_shift: transfer control, character setup and
// received-data return.
interface spi_shift_if #(
    parameter int CHAR_LEN_MAX = 32,
    parameter int LEN_W        = 5
);
    logic                    go;
    logic [LEN_W-1:0]        len;
    logic                    lsb;
    logic                    tx_negedge;
    logic                    rx_negedge;
    logic                    wr_en;
    logic [CHAR_LEN_MAX-1:0] wr_data;
    logic [CHAR_LEN_MAX-1:0] rx_data;
    logic                    done;

    modport master (
        output go, len, lsb, tx_negedge, rx_negedge, wr_en, wr_data,
        input  rx_data, done
    );

    modport slave (
        input  go, len, lsb, tx_negedge, rx_negedge, wr_en, wr_data,
        output rx_data, done
    );
endinterface

// File: rtl/spi_shift.sv
// SPI serial data engine: shifts MOSI and samples MISO on the SCLK edge
// strobes from spi_clgen, and reports tip/lstclk back to it.
module spi_shift #(
    parameter int CHAR_LEN_MAX = 32,
    parameter int LEN_W        = 5
) (
    input  logic        wb_clk,
    input  logic        wb_reset,
    input  logic        pos_edge,
    input  logic        neg_edge,
    input  logic        s_in,
    output logic        s_out,
    output logic        tip,
    output logic        lstclk,
    spi_shift_if.slave  bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;

    logic [0:0]              state;
    logic [CHAR_LEN_MAX-1:0] tx_reg;
    logic [CHAR_LEN_MAX-1:0] rx_reg;
    logic [LEN_W-1:0]        tx_idx;
    logic [LEN_W-1:0]        rx_idx;
    logic [LEN_W-1:0]        last_idx;
    logic                    lsb_q;
    logic                    done_q;

    logic                    tx_edge;
    logic                    rx_edge;
    logic                    rx_last;
    logic                    tx_advance;
    logic [LEN_W-1:0]        start_last;
    logic [LEN_W-1:0]        first_pos;
    logic [LEN_W-1:0]        rx_pos;
    logic [LEN_W-1:0]        tx_nxt;
    logic [LEN_W-1:0]        tx_pos_nxt;
    logic [CHAR_LEN_MAX-1:0] txd_start;

    assign tx_edge    = bus.tx_negedge ? neg_edge : pos_edge;
    assign rx_edge    = bus.rx_negedge ? neg_edge : pos_edge;

    // len==0 wraps to CHAR_LEN_MAX-1, which is exactly the last index.
    assign start_last = bus.len - LEN_W'(1);
    assign first_pos  = bus.lsb ? '0 : start_last;
    assign txd_start  = bus.wr_en ? bus.wr_data : tx_reg;

    assign rx_last    = (rx_idx == last_idx);
    assign rx_pos     = lsb_q ? rx_idx : last_idx - rx_idx;
    assign tx_nxt     = tx_idx + LEN_W'(1);
    assign tx_pos_nxt = lsb_q ? tx_nxt : last_idx - tx_nxt;
    // Launch the next bit only once the current one has been (or is being) sampled.
    assign tx_advance = tx_edge && (tx_idx < last_idx) && ((rx_idx > tx_idx) || rx_edge);

    assign tip         = (state == XFER);
    // NOTE: lstclk is decoded from registers only, so spi_clgen sees no combinational path from its own strobes.
    assign lstclk      = tip && rx_last;
    assign bus.rx_data = rx_reg;
    assign bus.done    = done_q;

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge wb_clk) begin
        if (wb_reset) begin
            state    <= IDLE;
            tx_reg   <= '0;
            rx_reg   <= '0;
            tx_idx   <= '0;
            rx_idx   <= '0;
            last_idx <= '0;
            lsb_q    <= 1'b0;
            done_q   <= 1'b0;
            s_out    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wr_en) begin
                        tx_reg <= bus.wr_data;
                    end
                    if (bus.go) begin
                        state    <= XFER;
                        tx_idx   <= '0;
                        rx_idx   <= '0;
                        rx_reg   <= '0;
                        last_idx <= start_last;
                        lsb_q    <= bus.lsb;
                        s_out    <= txd_start[first_pos];
                    end
                end
                XFER: begin
                    if (rx_edge) begin
                        rx_reg[rx_pos] <= s_in;
                        rx_idx         <= rx_idx + LEN_W'(1);
                        if (rx_last) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                    if (tx_advance) begin
                        tx_idx <= tx_nxt;
                        s_out  <= tx_reg[tx_pos_nxt];
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_shift.sv
// Directed bench for spi_shift: emulates spi_clgen strobes, models the
// expected bit stream, and scoreboards received characters.
module tb_spi_shift;
    logic        wb_clk = 1'b0;
    logic        wb_reset;
    logic        pos_edge;
    logic        neg_edge;
    logic        s_in;
    logic        s_out;
    logic        tip;
    logic        lstclk;

    logic        loop;
    logic        s_in_const;

    int          errors = 0;
    int          checks = 0;
    int          n;
    bit          lsb_m;
    logic [31:0] mdl_tx;
    logic [31:0] last_rx;
    logic        last_bit;
    logic [31:0] exp_q[$];

    spi_shift_if #(.CHAR_LEN_MAX(32), .LEN_W(5)) bus ();

    spi_shift #(.CHAR_LEN_MAX(32), .LEN_W(5)) dut (
        .wb_clk   (wb_clk),
        .wb_reset (wb_reset),
        .pos_edge (pos_edge),
        .neg_edge (neg_edge),
        .s_in     (s_in),
        .s_out    (s_out),
        .tip      (tip),
        .lstclk   (lstclk),
        .bus      (bus)
    );

    always #5 wb_clk = ~wb_clk;

    assign s_in = loop ? s_out : s_in_const;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic pulse(input bit is_pos);
        pos_edge = is_pos;
        neg_edge = !is_pos;
        tick();
        pos_edge = 1'b0;
        neg_edge = 1'b0;
    endtask

    function automatic logic [31:0] mask();
        return (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    endfunction

    function automatic logic exp_bit(input int i);
        int p;
        p = lsb_m ? i : n - 1 - i;
        return mdl_tx[p];
    endfunction

    task automatic wr(input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
        mdl_tx      = data;
    endtask

    task automatic start(input logic [31:0] data, input bit use_wr);
        if (use_wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = data;
            mdl_tx      = data;
        end
        bus.go = 1'b1;
        tick();
        bus.go    = 1'b0;
        bus.wr_en = 1'b0;
        n     = (bus.len == 0) ? 32 : int'(bus.len);
        lsb_m = bus.lsb;
        exp_q.push_back(loop ? (mdl_tx & mask()) : (s_in_const ? mask() : 32'h0));
        check("start_tip", {31'b0, tip}, 32'd1);
        check("start_sout", {31'b0, s_out}, {31'b0, exp_bit(0)});
        check("start_done_low", {31'b0, bus.done}, 32'd0);
        check("start_rx_clear", bus.rx_data, 32'h0);
    endtask

    // One pos then one neg strobe per bit; ends on the done cycle.
    task automatic run_bits(input bit mid_wr);
        for (int i = 0; i < n; i++) begin
            check($sformatf("lstclk_b%0d", i), {31'b0, lstclk}, {31'b0, (i == n - 1)});
            if (mid_wr && i == 2) begin
                bus.wr_en   = 1'b1;
                bus.wr_data = 32'h11;
            end
            pulse(1'b1);
            bus.wr_en = 1'b0;
            if (i < n - 1) begin
                check($sformatf("tip_b%0d", i), {31'b0, tip}, 32'd1);
                check($sformatf("sout_pos_b%0d", i), {31'b0, s_out},
                      {31'b0, bus.tx_negedge ? exp_bit(i) : exp_bit(i + 1)});
                pulse(1'b0);
                check($sformatf("sout_neg_b%0d", i), {31'b0, s_out}, {31'b0, exp_bit(i + 1)});
            end else begin
                check("done_pulse", {31'b0, bus.done}, 32'd1);
                check("tip_end", {31'b0, tip}, 32'd0);
                check("sout_hold", {31'b0, s_out}, {31'b0, exp_bit(n - 1)});
                last_bit = exp_bit(n - 1);
                if (exp_q.size() > 0) begin
                    last_rx = exp_q.pop_front();
                    check("rx_data", bus.rx_data, last_rx);
                end
            end
        end
    endtask

    initial begin
        wb_reset       = 1'b1;
        pos_edge       = 1'b0;
        neg_edge       = 1'b0;
        loop           = 1'b1;
        s_in_const     = 1'b0;
        bus.go         = 1'b0;
        bus.len        = 5'd8;
        bus.lsb        = 1'b0;
        bus.tx_negedge = 1'b1;
        bus.rx_negedge = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_data    = 32'h0;
        mdl_tx         = 32'h0;
        n              = 8;
        lsb_m          = 1'b0;
        repeat (3) tick();
        wb_reset = 1'b0;
        tick();
        check("reset_tip", {31'b0, tip}, 32'd0);
        check("reset_sout", {31'b0, s_out}, 32'd0);
        check("reset_lstclk", {31'b0, lstclk}, 32'd0);
        check("reset_done", {31'b0, bus.done}, 32'd0);
        check("reset_rx", bus.rx_data, 32'h0);

        // Mode 0, MSB first, 8 bits, loopback
        wr(32'hA5);
        start(32'h0, 1'b0);
        run_bits(1'b0);
        tick();
        check("m0_done_one_cycle", {31'b0, bus.done}, 32'd0);

        // LSB first, 32 bits, MISO tied high
        loop = 1'b0; s_in_const = 1'b1;
        bus.len = 5'd0; bus.lsb = 1'b1;
        wr(32'h8000_0001);
        start(32'h0, 1'b0);
        run_bits(1'b0);
        tick();

        // Same-edge mode, 4 bits, loopback
        loop = 1'b1; s_in_const = 1'b0;
        bus.len = 5'd4; bus.lsb = 1'b0; bus.tx_negedge = 1'b0;
        wr(32'h6);
        start(32'h0, 1'b0);
        run_bits(1'b0);
        tick();

        // go with wr_en together; mid-transfer write must be ignored
        bus.len = 5'd8; bus.tx_negedge = 1'b1;
        wr(32'hFF);
        start(32'h3C, 1'b1);
        run_bits(1'b1);
        tick();
        start(32'h0, 1'b0);
        run_bits(1'b0);
        tick();

        // Reset after the 3rd sample edge abandons the transfer
        start(32'hFF, 1'b1);
        void'(exp_q.pop_back());
        pulse(1'b1); pulse(1'b0);
        pulse(1'b1); pulse(1'b0);
        pulse(1'b1);
        wb_reset = 1'b1;
        tick();
        wb_reset = 1'b0;
        mdl_tx   = 32'h0;
        check("rst_mid_tip", {31'b0, tip}, 32'd0);
        check("rst_mid_rx", bus.rx_data, 32'h0);
        check("rst_mid_sout", {31'b0, s_out}, 32'd0);
        check("rst_mid_done", {31'b0, bus.done}, 32'd0);
        repeat (3) tick();
        check("rst_mid_no_done", {31'b0, bus.done}, 32'd0);
        start(32'h5A, 1'b1);
        run_bits(1'b0);
        tick();

        // Strobes while idle change nothing
        for (int i = 0; i < 10; i++) begin
            pulse(i[0]);
        end
        check("idle_tip", {31'b0, tip}, 32'd0);
        check("idle_sout", {31'b0, s_out}, {31'b0, last_bit});
        check("idle_rx", bus.rx_data, last_rx);

        // go on the done cycle starts the next transfer
        start(32'h96, 1'b1);
        run_bits(1'b0);
        start(32'h0F, 1'b1);
        run_bits(1'b0);
        tick();
        check("b2b_done_low", {31'b0, bus.done}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
